// File: rtl/ext_uart_tx_if.sv
// ext_uart_tx_if -- SoC external-port request bundle used by ext_uart_tx.
//
// Signals:
//   ext_addr   16  byte address of the request
//   ext_data    8  write byte
//   ext_wstrb   1  1 = write cycle, 0 = read cycle
//   ext_valid   1  request active; held until the SoC has seen ready
//   ext_ready   1  request may complete this cycle (driven by the peripheral)
//
// Modports:
//   master  SoC side: drives the request, observes ready
//   slave   peripheral side: observes the request, drives ready
interface ext_uart_tx_if;
  logic [15:0] ext_addr;
  logic [7:0]  ext_data;
  logic        ext_wstrb;
  logic        ext_valid;
  logic        ext_ready;

  modport master (
    output ext_addr,
    output ext_data,
    output ext_wstrb,
    output ext_valid,
    input  ext_ready
  );

  modport slave (
    input  ext_addr,
    input  ext_data,
    input  ext_wstrb,
    input  ext_valid,
    output ext_ready
  );
endinterface

// File: rtl/ext_uart_tx.sv
// ext_uart_tx -- byte-wide UART transmitter (8N1) behind a small TX FIFO,
// controlled from the SoC external port.
//
// Register map (writes only; reads and other addresses complete as no-ops):
//   0x0000 TXDATA  write pushes ext_data into the FIFO (stalls while full)
//   0x0004 CTRL    write with ext_data[0]=1 flushes the FIFO
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//   FIFO_AW       FIFO address width, depth = 2**FIFO_AW bytes
//
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   bus           ext_uart_tx_if.slave request bundle
//   o_uart_tx     registered serial line, idle high
//   o_busy        FIFO non-empty or frame in progress
//   o_fifo_level  bytes currently queued
module ext_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             rst,
  ext_uart_tx_if.slave     bus,
  output logic             o_uart_tx,
  output logic             o_busy,
  output logic [FIFO_AW:0] o_fifo_level
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   LVL_FULL    = (FIFO_AW + 1)'(DEPTH);
  localparam logic [15:0]        ADDR_TXDATA = 16'h0000;
  localparam logic [15:0]        ADDR_CTRL   = 16'h0004;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   baud_q;
  logic [2:0]         bit_q;
  logic [7:0]         shift_q;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   level_q;
  logic               acc_q;

  logic is_txdata;
  logic is_ctrl;
  logic txdata_wr;
  logic fifo_full;
  logic fifo_empty;
  logic action;
  logic push;
  logic flush;
  logic pop_slot;
  logic pop;

  assign is_txdata  = (bus.ext_addr == ADDR_TXDATA);
  assign is_ctrl    = (bus.ext_addr == ADDR_CTRL);
  assign txdata_wr  = bus.ext_wstrb & is_txdata;
  assign fifo_full  = (level_q == LVL_FULL);
  assign fifo_empty = (level_q == '0);

  // Only a fresh TXDATA write into a full FIFO is held off. Once the request
  // has been acted on, ready stays high so the SoC's registered view of ready
  // can retire it. While rst is high the FIFO is being emptied, so ready
  // reports the empty-FIFO answer.
  assign bus.ext_ready = rst | ~(txdata_wr & fifo_full & ~acc_q);

  // acc_q makes each request a one-shot: the SoC keeps valid high for at
  // least one cycle after it sees ready, and that extra cycle must not repeat
  // the push or flush.
  assign action = bus.ext_valid & bus.ext_wstrb & ~acc_q & bus.ext_ready;
  assign push   = action & is_txdata;
  assign flush  = action & is_ctrl & bus.ext_data[0];

  // The FSM takes the head byte either from IDLE or on the last STOP cycle,
  // which chains frames back to back without an idle bit between them.
  assign pop_slot = (state_q == IDLE) | ((state_q == STOP) & (baud_q == '0));
  assign pop      = pop_slot & ~fifo_empty;

  assign o_busy       = (state_q != IDLE) | ~fifo_empty;
  assign o_fifo_level = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (!bus.ext_valid) begin
      acc_q <= 1'b0;
    end else if (action) begin
      acc_q <= 1'b1;
    end
  end

  // A flush may land on the same edge as a pop; the FSM still takes the byte
  // it read, and the flush wins for the pointers and level.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + (FIFO_AW + 1)'(1);
        2'b01:   level_q <= level_q - (FIFO_AW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage has no reset; only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_q] <= bus.ext_data;
    end
  end

  // The line value is registered alongside each state change, so the line
  // moves on the same edge as the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      o_uart_tx <= 1'b1;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          o_uart_tx <= 1'b1;
          if (pop) begin
            shift_q   <= mem[rd_ptr_q];
            baud_q    <= CNT_MAX;
            o_uart_tx <= 1'b0;
            state_q   <= START;
          end
        end

        START: begin
          if (baud_q == '0) begin
            baud_q    <= CNT_MAX;
            bit_q     <= '0;
            o_uart_tx <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_q == '0) begin
            baud_q <= CNT_MAX;
            if (bit_q == 3'd7) begin
              o_uart_tx <= 1'b1;
              state_q   <= STOP;
            end else begin
              bit_q     <= bit_q + 3'd1;
              shift_q   <= shift_q >> 1;
              o_uart_tx <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_q == '0) begin
            if (pop) begin
              shift_q   <= mem[rd_ptr_q];
              baud_q    <= CNT_MAX;
              o_uart_tx <= 1'b0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q - CNT_W'(1);
          end
        end

        default: begin
          o_uart_tx <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_uart_tx.sv
// tb_ext_uart_tx -- directed self-checking bench for ext_uart_tx with
// CLKS_PER_BIT=4 and FIFO_AW=2 (depth 4). Inputs change 1 ns after a rising
// edge and outputs are sampled there too. A passive receiver decodes the
// serial line, sampling mid-bit, and records each byte and frame start time.
module tb_ext_uart_tx;

  localparam int CPB   = 4;
  localparam int AW    = 2;
  localparam int FRAME = 10 * CPB;
  localparam int LIMIT = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          o_uart_tx;
  logic          o_busy;
  logic [AW:0]   o_fifo_level;

  int            check_count = 0;
  int            pass_count  = 0;
  int            frame_err   = 0;
  logic [7:0]    rx_q[$];
  longint        rx_start_q[$];

  ext_uart_tx_if bus();

  ext_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_uart_tx   (o_uart_tx),
    .o_busy      (o_busy),
    .o_fifo_level(o_fifo_level)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [15:0] a, input logic [7:0] d,
                                input logic w, input logic v);
    bus.ext_addr  = a;
    bus.ext_data  = d;
    bus.ext_wstrb = w;
    bus.ext_valid = v;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  function automatic logic [31:0] rx_byte(input int idx);
    return (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rx_gap(input int idx);
    if (idx < 1 || idx >= rx_start_q.size()) return 32'hFFFF_FFFF;
    return 32'((rx_start_q[idx] - rx_start_q[idx-1]) / 10);
  endfunction

  // Write request: raise valid, wait (bounded) for ready, let the action edge
  // pass, hold valid one extra cycle as the SoC does, then one idle cycle.
  // lvl is the queue level right after the action edge.
  task automatic bus_write(input string tag, input logic [15:0] a,
                           input logic [7:0] d, output int waited,
                           output logic [AW:0] lvl);
    apply_stimulus(a, d, 1'b1, 1'b1);
    #1;
    waited = 0;
    while (bus.ext_ready !== 1'b1 && waited < LIMIT) begin
      tick();
      waited++;
    end
    check_output({tag, "_ready"}, 32'(bus.ext_ready), 1);
    tick();
    lvl = o_fifo_level;
    tick();
    apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int cycles;
    cycles = 0;
    while (o_busy !== 1'b0 && cycles < LIMIT) begin
      tick();
      cycles++;
    end
    check_output({tag, "_idle"}, 32'(o_busy), 0);
  endtask

  // Entered 1 ns after the edge on which the start bit began; samples each
  // bit mid-cell and returns 1 ns after the edge that ends the stop bit.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    check_output({tag, "_start_edge"}, 32'(o_uart_tx), 0);
    repeat (CPB / 2) tick();
    for (int k = 0; k < 10; k++) begin
      check_output($sformatf("%s_bit%0d", tag, k), 32'(o_uart_tx), 32'(bits[k]));
      if (k < 9) repeat (CPB) tick();
    end
    repeat (CPB / 2) tick();
  endtask

  initial begin : rx_monitor
    logic [9:0] sh;
    wait (rst === 1'b0);
    forever begin
      @(negedge o_uart_tx);
      rx_start_q.push_back($time);
      repeat (CPB / 2) @(posedge clk);
      #1;
      for (int k = 0; k < 10; k++) begin
        sh[k] = o_uart_tx;
        if (k < 9) begin
          repeat (CPB) @(posedge clk);
          #1;
        end
      end
      if (sh[0] !== 1'b0 || sh[9] !== 1'b1) frame_err++;
      rx_q.push_back(sh[8:1]);
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int          w;
    logic [AW:0] lvl;
    longint      t_fall;

    rst = 1'b1;
    apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] reset state");
    check_output("rst_ready", 32'(bus.ext_ready), 1);
    check_output("rst_tx", 32'(o_uart_tx), 1);
    check_output("rst_busy", 32'(o_busy), 0);
    check_output("rst_level", 32'(o_fifo_level), 0);
    rst = 1'b0;
    tick();

    $display("[TB] single frame 0x55");
    rx_q.delete();
    rx_start_q.delete();
    apply_stimulus(16'h0000, 8'h55, 1'b1, 1'b1);
    #1;
    check_output("t1_ready", 32'(bus.ext_ready), 1);
    tick();
    check_output("t1_level_e0", 32'(o_fifo_level), 1);
    check_output("t1_tx_e0", 32'(o_uart_tx), 1);
    check_output("t1_busy_e0", 32'(o_busy), 1);
    tick();
    apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    check_output("t1_level_e1", 32'(o_fifo_level), 0);
    check_frame("t1", 8'h55);
    check_output("t1_end_tx", 32'(o_uart_tx), 1);
    check_output("t1_end_busy", 32'(o_busy), 0);

    $display("[TB] valid held three cycles for 0xA5");
    rx_q.delete();
    rx_start_q.delete();
    apply_stimulus(16'h0000, 8'hA5, 1'b1, 1'b1);
    tick();
    check_output("t2_level_c1", 32'(o_fifo_level), 1);
    tick();
    check_output("t2_level_c2", 32'(o_fifo_level), 0);
    tick();
    check_output("t2_level_c3", 32'(o_fifo_level), 0);
    apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    tick();
    wait_idle("t2");
    check_output("t2_frames", 32'(rx_q.size()), 1);
    check_output("t2_byte", rx_byte(0), 32'hA5);

    $display("[TB] full FIFO stall and back-to-back frames");
    rx_q.delete();
    rx_start_q.delete();
    bus_write("t3_a", 16'h0000, 8'h11, w, lvl);
    bus_write("t3_b1", 16'h0000, 8'h22, w, lvl);
    bus_write("t3_b2", 16'h0000, 8'h33, w, lvl);
    bus_write("t3_b3", 16'h0000, 8'h44, w, lvl);
    bus_write("t3_b4", 16'h0000, 8'h55, w, lvl);
    check_output("t3_full_level", 32'(lvl), 4);
    apply_stimulus(16'h0000, 8'h66, 1'b1, 1'b1);
    #1;
    check_output("t3_stall_ready", 32'(bus.ext_ready), 0);
    repeat (5) tick();
    check_output("t3_stall_level", 32'(o_fifo_level), 4);
    check_output("t3_stall_ready_late", 32'(bus.ext_ready), 0);
    bus_write("t3_b5", 16'h0000, 8'h66, w, lvl);
    check_output("t3_b5_stalled", 32'(w > 0), 1);
    check_output("t3_b5_level", 32'(lvl), 4);
    wait_idle("t3");
    check_output("t3_frames", 32'(rx_q.size()), 6);
    check_output("t3_byte0", rx_byte(0), 32'h11);
    check_output("t3_byte1", rx_byte(1), 32'h22);
    check_output("t3_byte2", rx_byte(2), 32'h33);
    check_output("t3_byte3", rx_byte(3), 32'h44);
    check_output("t3_byte4", rx_byte(4), 32'h55);
    check_output("t3_byte5", rx_byte(5), 32'h66);
    for (int i = 1; i < 6; i++) begin
      check_output($sformatf("t3_gap%0d", i), rx_gap(i), FRAME);
    end
    check_output("t3_frame_err", 32'(frame_err), 0);

    $display("[TB] flush during first frame");
    rx_q.delete();
    rx_start_q.delete();
    bus_write("t4_a", 16'h0000, 8'h81, w, lvl);
    bus_write("t4_b", 16'h0000, 8'h42, w, lvl);
    bus_write("t4_c", 16'h0000, 8'hC3, w, lvl);
    check_output("t4_queued", 32'(lvl), 2);
    bus_write("t4_flush", 16'h0004, 8'h01, w, lvl);
    check_output("t4_flush_level", 32'(lvl), 0);
    check_output("t4_busy_mid", 32'(o_busy), 1);
    wait_idle("t4");
    t_fall = $time - 1;
    check_output("t4_busy_fall",
                 (rx_start_q.size() > 0) ? 32'((t_fall - rx_start_q[0]) / 10) : 32'hFFFF_FFFF,
                 FRAME);
    check_output("t4_frames", 32'(rx_q.size()), 1);
    check_output("t4_byte", rx_byte(0), 32'h81);
    repeat (50) tick();
    check_output("t4_idle_tx", 32'(o_uart_tx), 1);
    check_output("t4_idle_busy", 32'(o_busy), 0);
    check_output("t4_idle_level", 32'(o_fifo_level), 0);
    check_output("t4_no_more_frames", 32'(rx_start_q.size()), 1);
    check_output("t4_frame_err", 32'(frame_err), 0);

    $display("[TB] reset during data bit 3");
    rx_q.delete();
    rx_start_q.delete();
    bus_write("t5_a", 16'h0000, 8'hF0, w, lvl);
    bus_write("t5_b", 16'h0000, 8'h0F, w, lvl);
    check_output("t5_queued", 32'(lvl), 1);
    repeat (12) tick();
    check_output("t5_pre_tx", 32'(o_uart_tx), 0);
    check_output("t5_pre_level", 32'(o_fifo_level), 1);
    rst = 1'b1;
    #1;
    check_output("t5_rst_ready", 32'(bus.ext_ready), 1);
    tick();
    check_output("t5_rst_tx", 32'(o_uart_tx), 1);
    check_output("t5_rst_level", 32'(o_fifo_level), 0);
    check_output("t5_rst_busy", 32'(o_busy), 0);
    rst = 1'b0;
    apply_stimulus(16'h0010, 8'hFF, 1'b0, 1'b1);
    #1;
    check_output("t5_read_ready", 32'(bus.ext_ready), 1);
    tick();
    tick();
    check_output("t5_read_level", 32'(o_fifo_level), 0);
    check_output("t5_read_busy", 32'(o_busy), 0);
    check_output("t5_read_tx", 32'(o_uart_tx), 1);
    apply_stimulus(16'h0000, 8'h00, 1'b0, 1'b0);
    repeat (60) tick();
    check_output("t5_after_tx", 32'(o_uart_tx), 1);
    check_output("t5_after_busy", 32'(o_busy), 0);
    check_output("t5_discarded", 32'(rx_start_q.size()), 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
